// File: rtl/pulse_stretch_pkg.sv
// Shared types and constants for the pulse stretcher: FSM state encoding and
// the width of the pending-pulse counter.
package pulse_stretch_pkg;

  localparam int PEND_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Pulse request / stretched-level bundle between a pulse source (master) and
// the stretcher (slave).
interface pulse_stretcher_if;
  import pulse_stretch_pkg::*;

  logic              in;
  logic              out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (output in, input out, busy, pending, overflow);
  modport slave  (input in, output out, busy, pending, overflow);

endinterface

// File: rtl/pulse_stretcher_timer.sv
// cycle_timer: loadable down-counter shared by the HOLD and GAP phases;
// done_o flags the last cycle of the loaded interval.
module cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  // A load of N gives N cycles in the phase: done is raised while the count is 1.
  assign done_o = (count_q == W'(1));

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches each accepted input pulse to HOLD_CYCLES high
// followed by GAP_CYCLES low; queueing of pulses arriving while busy is
// enabled by the PULSE_STRETCH_QUEUE_EN macro.
module pulse_stretcher
  import pulse_stretch_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int QDEPTH      = 3
) (
  input  logic              clk,
  input  logic              reset,
  pulse_stretcher_if.slave  bus
);

`ifdef PULSE_STRETCH_QUEUE_EN
  localparam bit QUEUE_EN = 1'b1;
`else
  localparam bit QUEUE_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYCLES);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(QDEPTH);

  state_e              state_q, state_d;
  logic                out_q, busy_q;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_done;

  cycle_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    tmr_load = 1'b0;
    tmr_val  = HOLD_LD;

    unique case (state_q)
      IDLE: begin
        if (bus.in) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
        end
      end

      HOLD: begin
        if (QUEUE_EN && bus.in) begin
          if (pend_q == PEND_MAX) ovf_d  = 1'b1;
          else                    pend_d = pend_q + 1'b1;
        end
        if (tmr_done) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end

      GAP: begin
        if (tmr_done) begin
          // Final GAP edge: replay a queued pulse first; a pulse arriving on this
          // same edge takes the slot freed by the replay, so the count stays put.
          if (QUEUE_EN && pend_q != '0) begin
            state_d  = HOLD;
            tmr_load = 1'b1;
            if (!bus.in) pend_d = pend_q - 1'b1;
          end else if (QUEUE_EN && bus.in) begin
            state_d  = HOLD;
            tmr_load = 1'b1;
          end else begin
            state_d  = IDLE;
          end
        end else if (QUEUE_EN && bus.in) begin
          if (pend_q == PEND_MAX) ovf_d  = 1'b1;
          else                    pend_d = pend_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= (state_d == HOLD);
      busy_q  <= (state_d != IDLE);
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule
